gate_bist: RTL
==============

# gate_bist

Self-checking stimulus and compare engine for a small combinational gate under test. On `start` it drives every `{a,b}` operand combination exhaustively, waits a programmable settle time, and samples the gate output. It compares that output against a golden model chosen by `op_sel`, then reports mismatch count, first failing vector and pass/fail. It is the clocked, width-parametrised successor to our per-gate directed benches and can be instantiated in silicon as a gate-level BIST wrapper or in simulation as a checker.

## Interface
- `WIDTH`, 1: operand width in bits. Vector space is 2^(2·WIDTH).
- `SETTLE`, 2: cycles each vector is held before sampling; legal range ≥1.
- `CNT_W`, 8: width of the mismatch counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: run request, sampled in IDLE or DONE.
- `op_sel` in 3: golden op, latched at start. 0 XOR, 1 XNOR, 2 AND, 3 OR, 4 NAND, 5 NOR; 6–7 are reserved and treated as XOR.
- `a_o` out WIDTH: operand A to the gate under test.
- `b_o` out WIDTH: operand B to the gate under test.
- `dut_out_i` in WIDTH: gate-under-test output.
- `busy` out 1: run in progress.
- `done` out 1: level, run complete; held until the next start.
- `pass` out 1: `done` && `err_count`==0.
- `err_count` out CNT_W: failing vectors, saturating.
- `first_fail_vec` out 2·WIDTH: `{a,b}` of the first mismatch.
- `first_fail_valid` out 1: `first_fail_vec` holds a captured value.

## Operation
- States are IDLE, DRIVE, SAMPLE and DONE.
- IDLE→DRIVE on `start`. The transition clears the vector counter, settle counter, `err_count` and `first_fail_valid`, and latches `op_sel`.
- DRIVE lasts SETTLE cycles, then moves to SAMPLE.
- SAMPLE lasts one cycle and compares `dut_out_i` to the golden value bitwise.
  - Any bit differing counts as one failing vector.
  - On a failing vector, `err_count`+1, saturating at 2^CNT_W−1.
  - If `first_fail_valid`==0, the vector is captured into `first_fail_vec` and `first_fail_valid` is set.
- After SAMPLE:
  - If the vector is the last one (all ones), go to DONE.
  - Otherwise vector+1 and return to DRIVE.
- Vector mapping: `a_o` = vec[2W−1:W], `b_o` = vec[W−1:0]. For W=1 the order is 00, 01, 10, 11.
- `a_o`/`b_o` are registered and change only on the edge entering DRIVE.
- DONE→DRIVE on `start`, a full restart with results cleared.
- `start` while `busy` is ignored. A `start` held high across DONE restarts immediately.
- The vector counter is 2·WIDTH bits. Last-vector detection uses the all-ones compare, never the wrap to 0.

## Timing
- Reset values: `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0, state IDLE.
- Reset mid-run aborts immediately to these values; nothing is retained.
- `start` is sampled at edge k:
  - `busy`=1 and vector 0 are on the outputs from after edge k.
  - Each vector occupies SETTLE+1 cycles.
- `done`=1 and `busy`=0 from edge k + 2^(2W)·(SETTLE+1). For W=1, SETTLE=2 that is edge k+12.
- `err_count` and `first_fail_*` update on the edge ending SAMPLE, so the final value is stable when `done` rises.
- `busy` and `done` are never both high.

## Structure
- Package `gate_bist_pkg` holds:
  - the op encoding enum and the state enum;
  - the `golden(op, a, b)` function, parametrised on WIDTH via the caller's slice.
- Sub-module `gate_bist_golden` is the combinational reference model: op, a, b in; expected out.
  - It is instantiated once so it can be reused by other benches.

## Test plan
1. WIDTH=1, SETTLE=2, op XOR, DUT = a^b, start pulse → `a_o`/`b_o` step 00, 01, 10, 11 every 3 cycles; `done` at k+12; `err_count`=0; `pass`=1.
2. Same setup, DUT stuck-at-0 → `err_count`=2, `first_fail_vec`=2'b01, `first_fail_valid`=1, `pass`=0.
3. op XNOR against an XOR DUT → `err_count`=4, `first_fail_vec`=2'b00.
4. WIDTH=2, CNT_W=2, DUT=0, op OR → 15 failing vectors; `err_count` saturates at 3; `first_fail_vec`=4'b0001; `done` at k+48.
5. Deassert `rst_n` at cycle k+5 of a run → all outputs at reset values asynchronously. After release, a new start completes normally with `pass`=1.
6. Pulse `start` at k+4 (busy) → ignored, run ends at k+12. Then with a faulty DUT, `start` in DONE → counters cleared, rerun reports fresh `err_count`.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and golden-operation helper for the gate BIST engine.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'd0,
    OP_XNOR = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int unsigned GOLD_MAX_W = 32;

  // Callers zero-extend narrower operands and keep the low WIDTH bits of the result.
  function automatic logic [GOLD_MAX_W-1:0] golden(
    input logic [2:0]            op,
    input logic [GOLD_MAX_W-1:0] a,
    input logic [GOLD_MAX_W-1:0] b
  );
    logic [GOLD_MAX_W-1:0] r;
    case (op)
      OP_XNOR: r = ~(a ^ b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational reference model of the gate under test.
module gate_bist_golden
  import gate_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_o
);

  assign exp_o = WIDTH'(golden(op, GOLD_MAX_W'(a), GOLD_MAX_W'(b)));

endmodule

// File: rtl/gate_bist.sv
// Exhaustive stimulus/compare engine: walks every {a,b} vector, settles, samples, scores.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op_sel,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  input  logic [WIDTH-1:0]     dut_out_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic [SW-1:0]      set_q, set_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [VW-1:0]      ffv_q, ffv_d;
  logic               ffvld_q, ffvld_d;
  logic [WIDTH-1:0]   exp_val;
  logic               mismatch;

  gate_bist_golden #(.WIDTH(WIDTH)) u_golden (
    .op    (op_q),
    .a     (vec_q[VW-1:WIDTH]),
    .b     (vec_q[WIDTH-1:0]),
    .exp_o (exp_val)
  );

  assign mismatch = (dut_out_i != exp_val);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    op_d    = op_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvld_d = ffvld_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          set_d   = '0;
          op_d    = op_sel;
          err_d   = '0;
          ffv_d   = '0;
          ffvld_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (set_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                      set_d   = set_q + SW'(1);
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (!ffvld_q) begin
            ffv_d   = vec_q;
            ffvld_d = 1'b1;
          end
        end
        // All-ones compare ends the walk; the counter is never allowed to wrap.
        if (vec_q == '1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + VW'(1);
          set_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      op_q    <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
    end
  end

  assign a_o              = vec_q[VW-1:WIDTH];
  assign b_o              = vec_q[WIDTH-1:0];
  assign busy             = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

endmodule
